// File: rtl/timer_pkg.sv
// Shared constants and width helpers for the time-setting controller.
// sel encoding: 0 is RUN, k in 1..N_FIELDS-1 means field k is being set.
package timer_pkg;

   localparam int RUN_SEL = 0;

   function automatic int sel_width(input int n_fields);
      return (n_fields > 2) ? $clog2(n_fields) : 1;
   endfunction

   // Inactivity counter must be able to hold TIMEOUT_S itself.
   function automatic int tmo_width(input int timeout_s);
      return $clog2(timeout_s + 1);
   endfunction

endpackage

// File: rtl/timer_set_ctrl_edge_rise.sv
// One-bit synchronous rising-edge detector for a debounced button level.
// The first cycle after reset only primes the history, so a held button is not an edge.
module edge_rise (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic hist_reg;
   logic armed_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hist_reg  <= 1'b0;
         armed_reg <= 1'b0;
      end else begin
         hist_reg  <= din;
         armed_reg <= 1'b1;
      end
   end

   assign rise = din & ~hist_reg & armed_reg;

endmodule

// File: rtl/timer_set_ctrl.sv
// Time-setting controller: mode FSM, per-field increment enables, blink mask
// of the field being set, and auto-exit to RUN after TIMEOUT_S idle seconds.
module timer_set_ctrl
   import timer_pkg::*;
#(
   parameter int  N_FIELDS  = 3,
   parameter int  TIMEOUT_S = 10,
   localparam int SEL_W     = sel_width(N_FIELDS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick_1hz,
   input  logic                btn_mode,
   input  logic                btn_inc,
   input  logic [N_FIELDS-2:0] carry,
   output logic [N_FIELDS-1:0] field_inc,
   output logic                clr_lsf,
   output logic                set_active,
   output logic [SEL_W-1:0]    sel_field,
   output logic [N_FIELDS-1:0] blink_mask
);

   localparam int               CNT_W   = tmo_width(TIMEOUT_S);
   localparam logic [SEL_W-1:0] SEL_RUN = SEL_W'(RUN_SEL);
   localparam logic [SEL_W-1:0] SEL_TOP = SEL_W'(N_FIELDS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_S);

   logic                mode_edge;
   logic                inc_edge;
   logic [SEL_W-1:0]    sel_reg, sel_next;
   logic                phase_reg, phase_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [N_FIELDS-1:0] field_inc_reg, field_inc_next;
   logic [N_FIELDS-1:0] blink_reg, blink_next;
   logic                clr_reg, clr_next;
   logic                active_reg, active_next;
   logic [N_FIELDS-1:0] run_inc;
   logic                in_set;
   logic                entering;
   logic                timed_out;

   edge_rise u_mode_edge (.clk(clk), .rst_n(rst_n), .din(btn_mode), .rise(mode_edge));
   edge_rise u_inc_edge  (.clk(clk), .rst_n(rst_n), .din(btn_inc),  .rise(inc_edge));

   // Normal running: tick drives seconds, each carry drives the next field up.
   assign run_inc[0] = tick_1hz;
   for (genvar gi = 0; gi < N_FIELDS - 1; gi++) begin : g_ripple
      assign run_inc[gi+1] = carry[gi];
   end

   always_comb begin
      in_set         = (sel_reg != SEL_RUN);
      entering       = mode_edge && !in_set;
      timed_out      = in_set && (cnt_reg == CNT_MAX);
      sel_next       = sel_reg;
      phase_next     = phase_reg;
      cnt_next       = cnt_reg;
      field_inc_next = '0;
      blink_next     = '0;

      // A mode edge outranks a pending timeout.
      if (mode_edge) begin
         sel_next = in_set ? (sel_reg - SEL_W'(1)) : SEL_TOP;
      end else if (timed_out) begin
         sel_next = SEL_RUN;
      end

      if (entering) begin
         phase_next = 1'b0;
      end else if (in_set && tick_1hz) begin
         phase_next = ~phase_reg;
      end

      if (mode_edge || inc_edge) begin
         cnt_next = '0;
      end else if (in_set && tick_1hz && (cnt_reg != CNT_MAX)) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end

      // Outputs follow the current state, so a tick on the exit edge is dropped.
      if (!in_set) begin
         field_inc_next = run_inc;
      end else if (inc_edge && !mode_edge) begin
         for (int i = 1; i < N_FIELDS; i++) begin
            if (sel_reg == SEL_W'(i)) field_inc_next[i] = 1'b1;
         end
      end

      for (int i = 1; i < N_FIELDS; i++) begin
         if (sel_next == SEL_W'(i)) blink_next[i] = phase_next;
      end

      clr_next    = entering;
      active_next = (sel_next != SEL_RUN);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_reg       <= SEL_RUN;
         phase_reg     <= 1'b0;
         cnt_reg       <= '0;
         field_inc_reg <= '0;
         blink_reg     <= '0;
         clr_reg       <= 1'b0;
         active_reg    <= 1'b0;
      end else begin
         sel_reg       <= sel_next;
         phase_reg     <= phase_next;
         cnt_reg       <= cnt_next;
         field_inc_reg <= field_inc_next;
         blink_reg     <= blink_next;
         clr_reg       <= clr_next;
         active_reg    <= active_next;
      end
   end

   assign field_inc  = field_inc_reg;
   assign blink_mask = blink_reg;
   assign clr_lsf    = clr_reg;
   assign set_active = active_reg;
   assign sel_field  = sel_reg;

endmodule

// File: tb/tb_timer_set_ctrl.sv
// Scoreboard bench for timer_set_ctrl with N_FIELDS=3, TIMEOUT_S=3.
module tb_timer_set_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick_1hz = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [1:0] carry = 2'b00;
   logic [2:0] field_inc;
   logic       clr_lsf;
   logic       set_active;
   logic [1:0] sel_field;
   logic [2:0] blink_mask;

   timer_set_ctrl #(.N_FIELDS(3), .TIMEOUT_S(3)) dut (
      .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .btn_mode(btn_mode),
      .btn_inc(btn_inc), .carry(carry), .field_inc(field_inc), .clr_lsf(clr_lsf),
      .set_active(set_active), .sel_field(sel_field), .blink_mask(blink_mask)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cycle;
      logic [2:0] fi;
      logic       clr;
      logic [1:0] sel;
      logic       act;
      logic [2:0] blink;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  failures = 0;

   task automatic push_ev(input logic [2:0] fi, input logic clr, input logic [1:0] sel,
                          input logic act, input logic [2:0] blink);
      ev_t e;
      e.cycle = cyc + 1;
      e.fi = fi; e.clr = clr; e.sel = sel; e.act = act; e.blink = blink;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic t, input logic m, input logic i, input logic [1:0] c);
      tick_1hz = t; btn_mode = m; btn_inc = i; carry = c;
      @(posedge clk);
      #1;
      tick_1hz = 1'b0; carry = 2'b00;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
      end else begin
         $display("check %s cyc=%0d value=%0d ok", name, cyc, act);
      end
   endtask

   // Monitor: every cycle that shows an increment or clear pulse consumes one expected event.
   always @(negedge clk) begin : mon
      ev_t e;
      if ((|field_inc) === 1'b1 || clr_lsf === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse cyc=%0d actual fi=%b clr=%b required=no pulse",
                     cyc, field_inc, clr_lsf);
         end else begin
            e = exp_q.pop_front();
            if (cyc != e.cycle || field_inc != e.fi || clr_lsf != e.clr ||
                sel_field != e.sel || set_active != e.act || blink_mask != e.blink) begin
               failures++;
               $display("FAIL pulse_event actual cyc=%0d fi=%b clr=%b sel=%0d act=%b blink=%b required cyc=%0d fi=%b clr=%b sel=%0d act=%b blink=%b",
                        cyc, field_inc, clr_lsf, sel_field, set_active, blink_mask,
                        e.cycle, e.fi, e.clr, e.sel, e.act, e.blink);
            end else begin
               $display("event cyc=%0d fi=%b clr=%b sel=%0d ok", cyc, field_inc, clr_lsf, sel_field);
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      repeat (3) drive(0, 0, 0, 2'b00);
      chk("rst_sel", sel_field, 0);
      chk("rst_active", set_active, 0);
      chk("rst_field_inc", field_inc, 0);
      chk("rst_clr", clr_lsf, 0);
      chk("rst_blink", blink_mask, 0);
      rst_n = 1'b1;

      // RUN: five ticks, carry[0] after the third
      for (int k = 1; k <= 5; k++) begin
         push_ev(3'b001, 1'b0, 2'd0, 1'b0, 3'b000);
         drive(1, 0, 0, 2'b00);
         if (k == 3) begin
            push_ev(3'b010, 1'b0, 2'd0, 1'b0, 3'b000);
            drive(0, 0, 0, 2'b01);
         end else begin
            drive(0, 0, 0, 2'b00);
         end
      end
      chk("run_sel", sel_field, 0);

      // Enter SET_2, then four inc edges interleaved with ticks
      push_ev(3'b000, 1'b1, 2'd2, 1'b1, 3'b000);
      drive(0, 1, 0, 2'b00);
      drive(0, 0, 0, 2'b00);
      chk("set2_sel", sel_field, 2);
      chk("set2_active", set_active, 1);
      for (int k = 0; k < 4; k++) begin
         push_ev(3'b100, 1'b0, 2'd2, 1'b1, (k % 2 == 1) ? 3'b100 : 3'b000);
         drive(0, 0, 1, 2'b00);
         drive(1, 0, 0, 2'b00);
      end
      drive(0, 0, 0, 2'b00);
      chk("set2_blink_after_4ticks", blink_mask, 0);

      // SET_1, then idle timeout with blink toggling
      drive(0, 1, 0, 2'b00);
      drive(0, 0, 0, 2'b00);
      chk("set1_sel", sel_field, 1);
      drive(1, 0, 0, 2'b00);
      chk("blink_t1", blink_mask, 3'b010);
      drive(0, 0, 0, 2'b00);
      drive(1, 0, 0, 2'b00);
      chk("blink_t2", blink_mask, 3'b000);
      drive(0, 0, 0, 2'b00);
      drive(1, 0, 0, 2'b00);
      chk("blink_t3", blink_mask, 3'b010);
      chk("sel_before_timeout", sel_field, 1);
      drive(0, 0, 0, 2'b00);
      chk("timeout_sel", sel_field, 0);
      chk("timeout_active", set_active, 0);
      chk("timeout_blink", blink_mask, 0);

      // Inc edges in RUN do nothing
      repeat (2) begin
         drive(0, 0, 1, 2'b00);
         drive(0, 0, 0, 2'b00);
      end

      // Mode walk RUN -> SET_2 -> SET_1 -> RUN, last edge with a tick
      push_ev(3'b000, 1'b1, 2'd2, 1'b1, 3'b000);
      drive(0, 1, 0, 2'b00);
      drive(0, 0, 0, 2'b00);
      drive(0, 1, 0, 2'b00);
      drive(0, 0, 0, 2'b00);
      chk("walk_sel1", sel_field, 1);
      drive(1, 1, 0, 2'b00);
      chk("walk_sel0", sel_field, 0);
      chk("walk_active", set_active, 0);
      drive(0, 0, 0, 2'b00);

      // Mode and inc edges together in SET_2
      push_ev(3'b000, 1'b1, 2'd2, 1'b1, 3'b000);
      drive(0, 1, 0, 2'b00);
      drive(0, 0, 0, 2'b00);
      drive(0, 1, 1, 2'b00);
      chk("simul_sel", sel_field, 1);
      drive(0, 0, 0, 2'b00);

      // Back to SET_2 with btn_inc held, then reset mid-set
      drive(0, 1, 0, 2'b00);
      drive(0, 0, 0, 2'b00);
      chk("reenter_run", sel_field, 0);
      push_ev(3'b000, 1'b1, 2'd2, 1'b1, 3'b000);
      drive(0, 1, 0, 2'b00);
      drive(0, 0, 0, 2'b00);
      push_ev(3'b100, 1'b0, 2'd2, 1'b1, 3'b000);
      drive(0, 0, 1, 2'b00);
      drive(0, 0, 1, 2'b00);
      rst_n = 1'b0;
      drive(0, 0, 1, 2'b00);
      chk("midrst_sel", sel_field, 0);
      chk("midrst_active", set_active, 0);
      chk("midrst_field_inc", field_inc, 0);
      chk("midrst_blink", blink_mask, 0);
      rst_n = 1'b1;
      drive(0, 0, 1, 2'b00);
      drive(0, 0, 1, 2'b00);
      push_ev(3'b000, 1'b1, 2'd2, 1'b1, 3'b000);
      drive(0, 1, 1, 2'b00);
      drive(0, 0, 1, 2'b00);
      drive(0, 0, 1, 2'b00);
      chk("held_inc_sel", sel_field, 2);
      drive(0, 0, 0, 2'b00);
      push_ev(3'b100, 1'b0, 2'd2, 1'b1, 3'b000);
      drive(0, 0, 1, 2'b00);
      drive(0, 0, 0, 2'b00);
      repeat (3) drive(0, 0, 0, 2'b00);

      chk("pending_events", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
